// File: rtl/key_expansion.sv
// key_expansion: AES-128 key schedule, one round key per valid/ready handshake,
// each derived from the previous one so only the current key is stored.
module key_expansion #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] cipherKey,
  output logic [127:0] roundKey,
  output logic [3:0]   roundNum,
  output logic         roundKeyValid,
  input  logic         roundKeyReady,
  output logic         busy,
  output logic         done
);
  localparam logic IDLE = 1'b0;
  localparam logic EMIT = 1'b1;
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };
  logic state;
  logic [7:0] rcon;
  logic [31:0] rotW, subW, n0, n1, n2, n3;
  function automatic logic [7:0] sub(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction
  assign rotW = {roundKey[23:0], roundKey[31:24]};
  assign subW = {sub(rotW[31:24]), sub(rotW[23:16]), sub(rotW[15:8]), sub(rotW[7:0])} ^ {rcon, 24'h0};
  always_comb begin
    n0 = roundKey[127:96] ^ subW;
    n1 = roundKey[95:64] ^ n0;
    n2 = roundKey[63:32] ^ n1;
    n3 = roundKey[31:0] ^ n2;
  end
  assign roundKeyValid = state;
  assign busy = state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      roundKey <= '0;
      roundNum <= '0;
      rcon <= 8'h01;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          state <= EMIT;
          roundKey <= cipherKey;
          roundNum <= '0;
          rcon <= 8'h01;
        end
      end else if (roundKeyReady) begin
        if (roundNum == 4'(NUM_ROUNDS)) begin
          state <= IDLE;
          done <= 1'b1;
        end else begin
          roundKey <= {n0, n1, n2, n3};
          roundNum <= roundNum + 4'd1;
          rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        end
      end
    end
endmodule

// File: tb/tb_key_expansion.sv
// tb_key_expansion: random and directed AES-128 schedules against a word-array
// FIPS-197 model with an S-box derived from GF(2^8) inversion.
module tb_key_expansion;
  localparam int NR = 10;
  localparam logic [127:0] V1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  logic clk = 0, rst_n = 0, start = 0, roundKeyReady = 0;
  logic [127:0] cipherKey = '0;
  logic [127:0] roundKey;
  logic [3:0] roundNum;
  logic roundKeyValid, busy, done;
  key_expansion #(.NUM_ROUNDS(NR)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cipherKey(cipherKey),
    .roundKey(roundKey), .roundNum(roundNum), .roundKeyValid(roundKeyValid),
    .roundKeyReady(roundKeyReady), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [127:0] key; logic [3:0] num;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  logic [7:0] sbox[256];
  logic [127:0] seen[16];
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction
  function automatic void buildSbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 0, s;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = 8'h63;
      for (int k = 0; k < 5; k++) s ^= (inv << k) | (inv >> (8 - k));
      sbox[x] = s;
    end
  endfunction
  function automatic void pushSchedule(input logic [127:0] key);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++)
      sb.push_back('{key: {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]}, num: 4'(r)});
  endfunction
  // Monitor: sample mid-cycle, pop the scoreboard on every handshake.
  logic [127:0] prevKey;
  logic [3:0] prevNum;
  logic prevHold = 0, expDone = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) expDone = 0;
    chk("done", {127'b0, done}, {127'b0, expDone});
    if (prevHold && roundKeyValid) begin
      chk("hold key", roundKey, prevKey);
      chk("hold num", {124'b0, roundNum}, {124'b0, prevNum});
    end
    expDone = 0;
    if (roundKeyValid && roundKeyReady) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected key: got %h num %0d expected none", roundKey, roundNum);
      end else begin
        e = sb.pop_front();
        chk("key", roundKey, e.key);
        chk("num", {124'b0, roundNum}, {124'b0, e.num});
        seen[roundNum] = roundKey;
        expDone = (e.num == 4'(NR));
      end
    end
    prevHold = roundKeyValid && !roundKeyReady;
    prevKey = roundKey;
    prevNum = roundNum;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic runStart(input logic [127:0] key);
    cipherKey = key;
    start = 1;
    pushSchedule(key);
    tick();
    start = 0;
    cipherKey = rnd128();
  endtask
  task automatic waitDone(input bit rndReady, output int n);
    n = 0;
    do begin
      if (rndReady) roundKeyReady = 1'($urandom_range(0, 1));
      tick();
      n++;
    end while (!done && n < 400);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done timeout: got no done after %0d cycles expected done", n);
    end
  endtask
  task automatic waitRound(input logic [3:0] r);
    int n = 0;
    while (!(roundKeyValid && roundNum == r) && n < 100) begin
      tick();
      n++;
    end
    chk("reach round", {124'b0, roundNum}, {124'b0, r});
  endtask
  task automatic chkReset(input string tag);
    chk({tag, " key"}, roundKey, '0);
    chk({tag, " num"}, {124'b0, roundNum}, '0);
    chk({tag, " valid"}, {127'b0, roundKeyValid}, '0);
    chk({tag, " busy"}, {127'b0, busy}, '0);
    chk({tag, " done"}, {127'b0, done}, '0);
  endtask
  initial begin
    int n;
    buildSbox();
    repeat (2) tick();
    chkReset("reset");
    rst_n = 1;
    roundKeyReady = 1;
    repeat (3) tick();
    chk("idle ready valid", {127'b0, roundKeyValid}, '0);
    // Vector 1, continuous ready
    runStart(V1);
    waitDone(0, n);
    chk("v1 cycles", n, 11);
    chk("v1 r0", seen[0], V1);
    chk("v1 r1", seen[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("v1 r10", seen[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    tick();
    runStart('0);
    waitDone(0, n);
    chk("zero r1", seen[1], 128'h62636363626363636263636362636363);
    chk("zero r10", seen[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    // Random ready backpressure
    roundKeyReady = 0;
    runStart(V1);
    waitDone(1, n);
    chk("bp r10", seen[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    for (int i = 0; i < 4; i++) begin
      tick();
      runStart(rnd128());
      waitDone(1, n);
    end
    // Start while busy is ignored
    roundKeyReady = 1;
    tick();
    runStart(V1);
    waitRound(4'd4);
    start = 1;
    cipherKey = rnd128();
    tick();
    start = 0;
    chk("busy after ignored start", {127'b0, busy}, 1);
    waitDone(0, n);
    chk("ignored start r10", seen[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    // Reset mid-schedule
    tick();
    runStart(V1);
    waitRound(4'd6);
    rst_n = 0;
    sb.delete();
    #1;
    chkReset("async reset");
    repeat (2) tick();
    chkReset("held reset");
    rst_n = 1;
    tick();
    chk("no restart", {127'b0, roundKeyValid}, '0);
    runStart(V1);
    chk("restart num", {124'b0, roundNum}, '0);
    waitDone(0, n);
    chk("restart r10", seen[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    // Start in the done cycle
    runStart(rnd128());
    chk("done-cycle valid", {127'b0, roundKeyValid}, 1);
    chk("done-cycle num", {124'b0, roundNum}, '0);
    chk("done-cycle done", {127'b0, done}, '0);
    waitDone(0, n);
    chk("done-cycle cycles", n, 11);
    repeat (2) tick();
    chk("scoreboard empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
